sysid_checker: RTL and testbench

- Avalon-MM read master that sequences the system-ID slave at boot: reads the ID word (address 0), then the timestamp word (address 1), and compares both against build-time expected values.
- Sits between the Nios II system interconnect and board status logic (LEDs / hold-off of software start); reports pass, mismatch or bus timeout.
- Re-runnable on demand through a start pulse.

---
 rtl/sysid_checker.sv | 151 +++++++++++++++
 tb/tb_sysid_checker.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sysid_checker.sv
// Boot-time system-ID check: reads the ID word (address 0) and the timestamp word (address 1)
// over Avalon-MM and compares both with build-time values, flagging pass, mismatch or bus timeout.
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd12345678,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1431969997,
  parameter int unsigned TIMEOUT_CYCLES     = 255,
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        m_address,
  output logic        m_read,
  input  logic        m_waitrequest,
  input  logic [31:0] m_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout_err,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RD_ID = 2'd1,
    S_RD_TS = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_auto;
  logic        r_read;
  logic        r_addr;
  logic        r_busy;
  logic        r_done;
  logic        r_id_ok;
  logic        r_ts_ok;
  logic        r_timeout;
  logic [31:0] r_id_value;
  logic [31:0] r_ts_value;
  logic [15:0] r_cnt;
  logic        w_launch;
  logic        w_accept;
  logic        w_stall;
  logic        w_expire;

  // Avalon read handshake: a word transfers in any cycle with m_read=1 and m_waitrequest=0;
  // while m_read=1 and m_waitrequest=1 the address and strobe are held unchanged.
  assign w_accept = r_read & ~m_waitrequest;
  assign w_stall  = r_read & m_waitrequest;
  assign w_expire = w_stall & (r_cnt == CNT_LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start || r_auto) begin
          w_state_nxt = S_RD_ID;
          w_launch    = 1'b1;
        end
      end
      S_RD_ID: begin
        if (w_accept)      w_state_nxt = S_RD_TS;
        else if (w_expire) w_state_nxt = S_IDLE;
      end
      S_RD_TS: begin
        if (w_accept)      w_state_nxt = S_FIN;
        else if (w_expire) w_state_nxt = S_IDLE;
      end
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_auto     <= AUTO_START;
      r_read     <= 1'b0;
      r_addr     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_id_ok    <= 1'b0;
      r_ts_ok    <= 1'b0;
      r_timeout  <= 1'b0;
      r_id_value <= 32'd0;
      r_ts_value <= 32'd0;
      r_cnt      <= 16'd0;
    end else begin
      if (w_launch) begin
        r_auto    <= 1'b0;
        r_read    <= 1'b1;
        r_addr    <= 1'b0;
        r_busy    <= 1'b1;
        r_done    <= 1'b0;
        r_id_ok   <= 1'b0;
        r_ts_ok   <= 1'b0;
        r_timeout <= 1'b0;
        r_cnt     <= 16'd0;
      end
      if (r_state == S_RD_ID || r_state == S_RD_TS) begin
        if (w_accept) begin
          r_cnt <= 16'd0;
          if (r_state == S_RD_ID) begin
            r_id_value <= m_readdata;
            r_id_ok    <= (m_readdata == EXPECTED_ID);
            r_addr     <= 1'b1;
          end else begin
            r_ts_value <= m_readdata;
            r_ts_ok    <= (m_readdata == EXPECTED_TIMESTAMP);
            r_read     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
          end
        end else if (w_expire) begin
          // Abandon the run; any word not yet read keeps its cleared ok flag.
          r_cnt     <= 16'd0;
          r_read    <= 1'b0;
          r_busy    <= 1'b0;
          r_done    <= 1'b1;
          r_timeout <= 1'b1;
        end else if (w_stall) begin
          r_cnt <= r_cnt + 16'd1;
        end
      end
    end
  end

  assign m_read      = r_read;
  assign m_address   = r_addr;
  assign busy        = r_busy;
  assign done        = r_done;
  assign id_ok       = r_id_ok;
  assign ts_ok       = r_ts_ok;
  assign timeout_err = r_timeout;
  assign id_value    = r_id_value;
  assign ts_value    = r_ts_value;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_sysid_checker.sv
// Directed bench for sysid_checker: instance A auto-starts, instance B waits for start.
// Each instance has its own small Avalon slave with programmable wait states.
module tb_sysid_checker;

  localparam logic [31:0] ID_OK_WORD = 32'd12345678;
  localparam logic [31:0] TS_OK_WORD = 32'd1431969997;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- instance A: AUTO_START=1, TIMEOUT_CYCLES=8 ----------------
  logic        reset_n_a = 1'b0, start_a = 1'b0;
  logic        m_address_a, m_read_a, busy_a, done_a, id_ok_a, ts_ok_a, to_a;
  logic        wr_a = 1'b0;
  logic [31:0] rd_a = 32'd0, id_value_a, ts_value_a;
  logic [1:0]  dbg_a;

  sysid_checker #(.TIMEOUT_CYCLES(8), .AUTO_START(1'b1)) dut_a (
    .clock(clock), .reset_n(reset_n_a), .start(start_a),
    .m_address(m_address_a), .m_read(m_read_a), .m_waitrequest(wr_a), .m_readdata(rd_a),
    .busy(busy_a), .done(done_a), .id_ok(id_ok_a), .ts_ok(ts_ok_a), .timeout_err(to_a),
    .id_value(id_value_a), .ts_value(ts_value_a), .dbg_state(dbg_a)
  );

  // ---------------- instance B: AUTO_START=0, TIMEOUT_CYCLES=8 ----------------
  logic        reset_n_b = 1'b0, start_b = 1'b0;
  logic        m_address_b, m_read_b, busy_b, done_b, id_ok_b, ts_ok_b, to_b;
  logic        wr_b = 1'b0;
  logic [31:0] rd_b = 32'd0, id_value_b, ts_value_b;
  logic [1:0]  dbg_b;

  sysid_checker #(.TIMEOUT_CYCLES(8), .AUTO_START(1'b0)) dut_b (
    .clock(clock), .reset_n(reset_n_b), .start(start_b),
    .m_address(m_address_b), .m_read(m_read_b), .m_waitrequest(wr_b), .m_readdata(rd_b),
    .busy(busy_b), .done(done_b), .id_ok(id_ok_b), .ts_ok(ts_ok_b), .timeout_err(to_b),
    .id_value(id_value_b), .ts_value(ts_value_b), .dbg_state(dbg_b)
  );

  // ---------------- slave models (update on the falling edge) ----------------
  logic [31:0] id_mem_a = ID_OK_WORD, ts_mem_a = TS_OK_WORD;
  int          ws_a = 0, cnt_a = 0;
  bit          stuck_a = 1'b0, prev_stall_a = 1'b0;
  logic        prev_addr_a = 1'b0;

  always @(negedge clock) begin
    if (reset_n_a && prev_stall_a && m_read_a) chk("hold_addr_a", 32'(m_address_a), 32'(prev_addr_a));
    if (!m_read_a) begin
      wr_a = 1'b0; cnt_a = 0;
    end else if (stuck_a || cnt_a < ws_a) begin
      wr_a = 1'b1; cnt_a++;
    end else begin
      wr_a = 1'b0; cnt_a = 0;
      rd_a = m_address_a ? ts_mem_a : id_mem_a;
    end
    prev_stall_a = reset_n_a && m_read_a && wr_a;
    prev_addr_a  = m_address_a;
  end

  int          cnt_b = 0;
  bit          stuck_b = 1'b0, prev_stall_b = 1'b0;
  logic        prev_addr_b = 1'b0;

  always @(negedge clock) begin
    if (reset_n_b && prev_stall_b && m_read_b) chk("hold_addr_b", 32'(m_address_b), 32'(prev_addr_b));
    if (!m_read_b) begin
      wr_b = 1'b0; cnt_b = 0;
    end else if (stuck_b) begin
      wr_b = 1'b1; cnt_b++;
    end else begin
      wr_b = 1'b0; cnt_b = 0;
      rd_b = m_address_b ? TS_OK_WORD : ID_OK_WORD;
    end
    prev_stall_b = reset_n_b && m_read_b && wr_b;
    prev_addr_b  = m_address_b;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Called just after an edge; returns one cycle later, i.e. in "cycle 1" of the run.
  task automatic pulse(input int which);
    if (which == 0) start_a = 1'b1; else start_b = 1'b1;
    step();
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    #3;
    chk("rst_read_a", 32'(m_read_a), 32'd0);
    chk("rst_busy_a", 32'(busy_a), 32'd0);
    chk("rst_done_a", 32'(done_a), 32'd0);
    chk("rst_idval_a", id_value_a, 32'd0);
    #9 reset_n_a = 1'b1;

    // 1) zero-wait auto-start pass
    step();
    chk("t1_c1_read", 32'(m_read_a), 32'd1);
    chk("t1_c1_addr", 32'(m_address_a), 32'd0);
    chk("t1_c1_busy", 32'(busy_a), 32'd1);
    step();
    chk("t1_c2_read", 32'(m_read_a), 32'd1);
    chk("t1_c2_addr", 32'(m_address_a), 32'd1);
    chk("t1_c2_done", 32'(done_a), 32'd0);
    step();
    chk("t1_c3_read", 32'(m_read_a), 32'd0);
    chk("t1_c3_done", 32'(done_a), 32'd1);
    chk("t1_c3_busy", 32'(busy_a), 32'd0);
    chk("t1_c3_state", 32'(dbg_a), 32'd3);
    chk("t1_id_ok", 32'(id_ok_a), 32'd1);
    chk("t1_ts_ok", 32'(ts_ok_a), 32'd1);
    chk("t1_to", 32'(to_a), 32'd0);
    chk("t1_idval", id_value_a, ID_OK_WORD);
    chk("t1_tsval", ts_value_a, TS_OK_WORD);
    step(); step();
    chk("t1_no_rerun", 32'(m_read_a), 32'd0);
    chk("t1_done_sticky", 32'(done_a), 32'd1);

    // 2) three wait states per read, wrong ID
    id_mem_a = 32'hDEADBEEF;
    ws_a     = 3;
    pulse(0);
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("t2_c%0d_read", i), 32'(m_read_a), 32'd1);
      chk($sformatf("t2_c%0d_addr", i), 32'(m_address_a), (i > 4) ? 32'd1 : 32'd0);
      chk($sformatf("t2_c%0d_done", i), 32'(done_a), 32'd0);
      step();
    end
    chk("t2_c9_read", 32'(m_read_a), 32'd0);
    chk("t2_c9_done", 32'(done_a), 32'd1);
    chk("t2_idval", id_value_a, 32'hDEADBEEF);
    chk("t2_id_ok", 32'(id_ok_a), 32'd0);
    chk("t2_ts_ok", 32'(ts_ok_a), 32'd1);
    chk("t2_to", 32'(to_a), 32'd0);

    // 4) start during busy and on the FIN cycle is ignored; start in IDLE reruns
    id_mem_a = ID_OK_WORD;
    ws_a     = 0;
    step();
    pulse(0);
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    chk("t4_c2_addr", 32'(m_address_a), 32'd1);
    chk("t4_c2_read", 32'(m_read_a), 32'd1);
    step();
    chk("t4_c3_done", 32'(done_a), 32'd1);
    chk("t4_c3_read", 32'(m_read_a), 32'd0);
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    chk("t4_c4_read", 32'(m_read_a), 32'd0);
    chk("t4_c4_busy", 32'(busy_a), 32'd0);
    step();
    chk("t4_c5_read", 32'(m_read_a), 32'd0);
    chk("t4_c5_done", 32'(done_a), 32'd1);
    pulse(0);
    chk("t4_rerun_done", 32'(done_a), 32'd0);
    chk("t4_rerun_busy", 32'(busy_a), 32'd1);
    chk("t4_rerun_read", 32'(m_read_a), 32'd1);
    step(); step();
    chk("t4_rerun_done3", 32'(done_a), 32'd1);
    chk("t4_rerun_id_ok", 32'(id_ok_a), 32'd1);

    // 3) waitrequest stuck high -> timeout after 8 stalled cycles at address 0
    stuck_a = 1'b1;
    step();
    pulse(0);
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("t3_c%0d_read", i), 32'(m_read_a), 32'd1);
      chk($sformatf("t3_c%0d_addr", i), 32'(m_address_a), 32'd0);
      step();
    end
    chk("t3_c9_read", 32'(m_read_a), 32'd0);
    chk("t3_to", 32'(to_a), 32'd1);
    chk("t3_done", 32'(done_a), 32'd1);
    chk("t3_busy", 32'(busy_a), 32'd0);
    chk("t3_id_ok", 32'(id_ok_a), 32'd0);
    chk("t3_ts_ok", 32'(ts_ok_a), 32'd0);
    chk("t3_idval_kept", id_value_a, ID_OK_WORD);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t3_no_ts_read", 32'(m_read_a), 32'd0);
    end
    stuck_a = 1'b0;

    // 6) AUTO_START=0: idle for 100 cycles, then a start gives a normal pass
    reset_n_b = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      chk("t6_idle_read", 32'(m_read_b), 32'd0);
      chk("t6_idle_busy", 32'(busy_b), 32'd0);
    end
    pulse(1);
    chk("t6_c1_read", 32'(m_read_b), 32'd1);
    chk("t6_c1_addr", 32'(m_address_b), 32'd0);
    step();
    chk("t6_c2_addr", 32'(m_address_b), 32'd1);

    // 5) reset during a stalled timestamp read
    stuck_b = 1'b1;
    step();
    chk("t5_c3_read", 32'(m_read_b), 32'd1);
    chk("t5_c3_addr", 32'(m_address_b), 32'd1);
    chk("t5_c3_busy", 32'(busy_b), 32'd1);
    step();
    chk("t5_c4_read", 32'(m_read_b), 32'd1);
    #2 reset_n_b = 1'b0;
    #1;
    chk("t5_rst_read", 32'(m_read_b), 32'd0);
    chk("t5_rst_addr", 32'(m_address_b), 32'd0);
    chk("t5_rst_busy", 32'(busy_b), 32'd0);
    chk("t5_rst_done", 32'(done_b), 32'd0);
    chk("t5_rst_id_ok", 32'(id_ok_b), 32'd0);
    chk("t5_rst_to", 32'(to_b), 32'd0);
    chk("t5_rst_idval", id_value_b, 32'd0);
    chk("t5_rst_tsval", ts_value_b, 32'd0);
    stuck_b = 1'b0;
    @(negedge clock);
    #2 reset_n_b = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t5_post_read", 32'(m_read_b), 32'd0);
    end
    chk("t5_post_state", 32'(dbg_b), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
